// File: rtl/assoc_cache.sv
// Set-associative write-through, no-write-allocate data cache with tree-PLRU.
// Define CACHE_WBUF_EN to add a one-entry posted write buffer.
module assoc_cache #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 256,
  parameter int WORDS_PER_LINE = 2,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 32'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            modeAddr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  WE,
  input  logic                  RE,
  input  logic                  trigger,
  output logic                  miss_stall,
  output logic [WIDTH-1:0]      cache_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [WIDTH/8-1:0]    mem_be,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      mem_rdata
);
  localparam int NB  = WIDTH / 8;
  localparam int OB  = $clog2(NB);
  localparam int WB  = $clog2(WORDS_PER_LINE);
  localparam int WBW = (WB > 0) ? WB : 1;
  localparam int IB  = $clog2(SETS);
  localparam int TB  = ADDR_WIDTH - OB - WB - IB;
  localparam int PB  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WYB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LMASK =
    ADDR_WIDTH'(WORDS_PER_LINE * NB - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t           state;
  logic [WBW-1:0]   beat;
  logic [SETS-1:0]  vld  [WAYS];
  logic [TB-1:0]    tags [WAYS][SETS];
  logic [WIDTH-1:0] dat  [WAYS][SETS][WORDS_PER_LINE];
  logic [PB-1:0]    plru [SETS];
  logic [WIDTH-1:0] lbuf [WORDS_PER_LINE];

  logic [IB-1:0]         idx;
  logic [TB-1:0]         tag;
  logic [WBW-1:0]        wsel;
  logic [OB-1:0]         lane;
  logic                  is_trig, is_byte, hit, last, fill_done;
  logic                  found, wb_busy, st_upd;
  logic [WYB-1:0]        hway, vway;
  logic [NB-1:0]         sbe;
  logic [WIDTH-1:0]      swd;
  logic [ADDR_WIDTH-1:0] fill_addr, word_addr;

  function automatic logic [WYB-1:0] plru_way(input logic [PB-1:0] p);
    logic [2:0] q;
    q = 3'(p);
    if (WAYS == 4) return WYB'(q[0] ? {1'b1, q[2]} : {1'b0, q[1]});
    if (WAYS == 2) return WYB'(q[0]);
    return '0;
  endfunction

  // Point the tree away from the way just touched.
  function automatic logic [PB-1:0] plru_upd(input logic [PB-1:0] p,
                                             input logic [WYB-1:0] w);
    logic [2:0] q;
    logic [1:0] ww;
    q  = 3'(p);
    ww = 2'(w);
    if (WAYS == 2) q[0] = ~ww[0];
    else if (WAYS == 4) begin
      q[0] = ~ww[1];
      if (ww[1]) q[2] = ~ww[0];
      else       q[1] = ~ww[0];
    end
    return PB'(q);
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] o,
                                             input logic [WIDTH-1:0] n,
                                             input logic [NB-1:0]    be);
    logic [WIDTH-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  assign idx       = addr[OB+WB +: IB];
  assign tag       = addr[ADDR_WIDTH-1 -: TB];
  assign wsel      = (WB > 0) ? addr[OB +: WBW] : '0;
  assign lane      = addr[OB-1:0];
  assign is_trig   = addr == TRIGGER_ADDR;
  assign is_byte   = (modeAddr == 3'b011) || (modeAddr == 3'b101);
  assign sbe       = is_byte ? (NB'(1) << lane) : '1;
  assign swd       = is_byte ? (WIDTH'(write_data[7:0]) << {lane, 3'b000})
                             : write_data;
  assign word_addr = addr & ~ADDR_WIDTH'(NB - 1);
  assign fill_addr = (addr & ~LMASK) | (ADDR_WIDTH'(beat) << OB);
  assign last      = beat == WBW'(WORDS_PER_LINE - 1);
  assign fill_done = (state == FILL) && mem_ack && last;

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++)
      if (vld[w][idx] && tags[w][idx] == tag) begin
        hit  = 1'b1;
        hway = WYB'(w);
      end
  end

  always_comb begin
    found = 1'b0;
    vway  = plru_way(plru[idx]);
    for (int w = 0; w < WAYS; w++)
      if (!found && !vld[w][idx]) begin
        found = 1'b1;
        vway  = WYB'(w);
      end
  end

`ifdef CACHE_WBUF_EN
  logic                  wb_vld, st_take;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic [NB-1:0]         wb_be;

  assign wb_busy = wb_vld;
  assign st_take = (state == IDLE) && WE && !RE && !is_trig && !wb_vld;
  assign st_upd  = st_take && hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_vld <= 1'b0;
    else if (st_take) wb_vld <= 1'b1;
    else if (state == IDLE && wb_vld && mem_ack) wb_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (st_take) begin
      wb_addr <= word_addr;
      wb_data <= swd;
      wb_be   <= sbe;
    end
  end
`else
  assign wb_busy = 1'b0;
  assign st_upd  = (state == WRITE) && mem_ack && hit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
      for (int w = 0; w < WAYS; w++) vld[w] <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (RE && !is_trig) begin
            if (hit) plru[idx] <= plru_upd(plru[idx], hway);
            else if (!wb_busy) state <= FILL;
          end
`ifndef CACHE_WBUF_EN
          else if (WE && !is_trig) state <= WRITE;
`endif
        end
        FILL: if (mem_ack) begin
          if (last) begin
            beat           <= '0;
            state          <= IDLE;
            vld[vway][idx] <= 1'b1;
            plru[idx]      <= plru_upd(plru[idx], vway);
          end else begin
            beat <= beat + WBW'(1);
          end
        end
        WRITE: if (mem_ack) state <= DONE;
        DONE:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) lbuf[beat] <= mem_rdata;
    if (fill_done) begin
      tags[vway][idx] <= tag;
      for (int b = 0; b < WORDS_PER_LINE; b++)
        dat[vway][idx][b] <= (WBW'(b) == beat) ? mem_rdata : lbuf[b];
    end
    if (st_upd) dat[hway][idx][wsel] <= merge(dat[hway][idx][wsel], swd, sbe);
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    miss_stall = 1'b0;
    cache_out  = '0;
    unique case (state)
      IDLE: begin
        if (RE) begin
          if (is_trig)  cache_out  = WIDTH'(trigger);
          else if (hit) cache_out  = dat[hway][idx][wsel];
          else          miss_stall = 1'b1;
        end else if (WE && !is_trig) begin
`ifdef CACHE_WBUF_EN
          miss_stall = wb_vld;
`else
          miss_stall = 1'b1;
`endif
        end
`ifdef CACHE_WBUF_EN
        if (wb_vld) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wb_addr;
          mem_wdata = wb_data;
          mem_be    = wb_be;
        end
`endif
      end
      FILL: begin
        mem_req    = 1'b1;
        mem_addr   = fill_addr;
        miss_stall = 1'b1;
      end
      WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = word_addr;
        mem_wdata  = swd;
        mem_be     = sbe;
        miss_stall = 1'b1;
      end
      DONE: miss_stall = 1'b0;
    endcase
    if (!rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;
      miss_stall = 1'b0;
      cache_out  = '0;
    end
  end
endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: directed loads/stores against a
// word memory model with configurable ack latency.
module tb_assoc_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  modeAddr = 3'b010;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        WE = 1'b0;
  logic        RE = 1'b0;
  logic        trigger = 1'b0;
  logic        miss_stall;
  logic [31:0] cache_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  assoc_cache dut (
    .clk(clk), .rst(rst), .modeAddr(modeAddr), .addr(addr),
    .write_data(write_data), .WE(WE), .RE(RE), .trigger(trigger),
    .miss_stall(miss_stall), .cache_out(cache_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          stalls;
    string       name;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } beat_t;

  exp_t  eq[$];
  beat_t bq[$];
  exp_t  e;
  beat_t bb;
  int    checks = 0;
  int    failures = 0;
  int    scnt = 0;

  logic [31:0] mem [0:65535];
  int wait_n = 0;
  int wcnt = 0;

  assign mem_ack   = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr[17:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ack && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[17:2]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response monitor: retire = request held with miss_stall low.
  always @(negedge clk) begin
    if (!rst) scnt = 0;
    else if (RE || WE) begin
      if (miss_stall) scnt++;
      else begin
        chk("resp_queue", eq.size() != 0, 1);
        if (eq.size() != 0) begin
          e = eq.pop_front();
          if (e.rd) chk({e.name, "_data"}, cache_out, e.data);
          chk({e.name, "_stall"}, scnt, e.stalls);
        end
        scnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && mem_req && mem_ack) begin
      chk("beat_queue", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        bb = bq.pop_front();
        chk("beat_we", mem_we, bb.we);
        chk("beat_addr", mem_addr, bb.a);
        if (bb.we) begin
          chk("beat_wdata", mem_wdata, bb.wd);
          chk("beat_be", mem_be, bb.be);
        end
      end
    end
  end

  task automatic exp_rd(input string nm, input logic [31:0] d, input int st);
    exp_t x;
    x = '{1'b1, d, st, nm};
    eq.push_back(x);
  endtask

  task automatic exp_wr(input string nm, input int st);
    exp_t x;
    x = '{1'b0, 32'h0, st, nm};
    eq.push_back(x);
  endtask

  task automatic exp_beat(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    beat_t x;
    x = '{we, a, wd, be};
    bq.push_back(x);
  endtask

  task automatic req(input bit rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] md);
    int n;
    addr = a;
    write_data = wd;
    modeAddr = md;
    RE = rd;
    WE = !rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (miss_stall && n < 200);
    chk("req_timeout", miss_stall, 0);
    @(posedge clk);
    #1;
    RE = 1'b0;
    WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[16'h4000] = 32'hDEADBEEF;

    // Reset: outputs quiet even with a load request presented.
    RE = 1'b1;
    addr = 32'h10000;
    repeat (3) @(negedge clk);
    chk("rst_stall", miss_stall, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_memwdata", mem_wdata, 0);
    chk("rst_membe", mem_be, 0);
    chk("rst_out", cache_out, 0);
    RE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    exp_beat(0, 32'h10000, 0, 0);
    exp_beat(0, 32'h10004, 0, 0);
    exp_rd("miss0", 32'hDEADBEEF, 3);
    req(1, 32'h10000, 0, 3'b010);
    exp_rd("hit0", 32'hDEADBEEF, 0);
    req(1, 32'h10000, 0, 3'b010);

    wait_n = 3;
    exp_beat(0, 32'h10800, 0, 0);
    exp_beat(0, 32'h10804, 0, 0);
    exp_rd("miss_w3", 32'hC0DE4200, 9);
    req(1, 32'h10800, 0, 3'b010);
    wait_n = 0;

    exp_rd("hit_touch", 32'hDEADBEEF, 0);
    req(1, 32'h10000, 0, 3'b010);
    exp_beat(0, 32'h11000, 0, 0);
    exp_beat(0, 32'h11004, 0, 0);
    exp_rd("miss_evict", 32'hC0DE4400, 3);
    req(1, 32'h11000, 0, 3'b010);
    exp_rd("hit_kept", 32'hDEADBEEF, 0);
    req(1, 32'h10000, 0, 3'b010);
    exp_beat(0, 32'h10800, 0, 0);
    exp_beat(0, 32'h10804, 0, 0);
    exp_rd("miss_evicted", 32'hC0DE4200, 3);
    req(1, 32'h10800, 0, 3'b010);

    exp_beat(1, 32'h10000, 32'h0000AB00, 4'b0010);
    exp_wr("st_byte", 2);
    req(0, 32'h10001, 32'h123456AB, 3'b011);
    exp_rd("rd_after_byte", 32'hDEADABEF, 0);
    req(1, 32'h10000, 0, 3'b010);

    wait_n = 3;
    exp_beat(1, 32'h12000, 32'hCAFEF00D, 4'b1111);
    exp_wr("st_word_w3", 5);
    req(0, 32'h12000, 32'hCAFEF00D, 3'b010);
    wait_n = 0;
    exp_beat(0, 32'h12000, 0, 0);
    exp_beat(0, 32'h12004, 0, 0);
    exp_rd("no_alloc", 32'hCAFEF00D, 3);
    req(1, 32'h12000, 0, 3'b010);

    trigger = 1'b1;
    exp_rd("trig", 32'h1, 0);
    addr = 32'h100;
    RE = 1'b1;
    @(negedge clk);
    chk("trig_memreq", mem_req, 0);
    @(posedge clk);
    #1;
    RE = 1'b0;
    trigger = 1'b0;

    exp_beat(1, 32'h10004, 32'h005A0000, 4'b0100);
    exp_wr("st_byte101", 2);
    req(0, 32'h10006, 32'h0000005A, 3'b101);
    exp_rd("rd_after_b101", 32'hC05A4001, 0);
    req(1, 32'h10004, 0, 3'b010);

    // Reset during the second fill beat.
    wait_n = 3;
    exp_beat(0, 32'h20010, 0, 0);
    addr = 32'h20010;
    modeAddr = 3'b010;
    RE = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_ack) && n < 100);
    chk("mid_beat0_seen", mem_req && mem_ack, 1);
    @(posedge clk);
    #2;
    chk("mid_beat1_req", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_memreq", mem_req, 0);
    chk("mid_rst_stall", miss_stall, 0);
    chk("mid_rst_memaddr", mem_addr, 0);
    RE = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    wait_n = 0;
    exp_beat(0, 32'h20010, 0, 0);
    exp_beat(0, 32'h20014, 0, 0);
    exp_rd("post_rst_miss", 32'hC0DE8004, 3);
    req(1, 32'h20010, 0, 3'b010);
    exp_rd("post_rst_hit", 32'hC0DE8005, 0);
    req(1, 32'h20014, 0, 3'b010);
    exp_beat(0, 32'h10000, 0, 0);
    exp_beat(0, 32'h10004, 0, 0);
    exp_rd("cold_after_rst", 32'hDEADABEF, 3);
    req(1, 32'h10000, 0, 3'b010);

    repeat (3) @(negedge clk);
    chk("resp_drained", eq.size(), 0);
    chk("beats_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
